// File: rtl/serial_word_loader_if.sv
// rtl/serial_word_loader_if.sv - serial frame input, word output and status signals of serial_word_loader
//
// Signals:
//   SIN    serial frame data, idles high
//   SEN    bit-sample enable; SIN is only looked at when SEN=1
//   D      assembled 4-bit word
//   VALID  D holds a word not yet taken downstream
//   READY  downstream register accepts D this cycle
//   PERR   one-cycle parity-error pulse
//   FERR   one-cycle framing-error pulse
//   OVF    sticky overflow flag
//
// master: the loader itself (drives D/VALID and status, receives SIN/SEN/READY)
// slave:  the environment around it (serial source plus downstream register)

interface serial_word_loader_if;
    logic       SIN;
    logic       SEN;
    logic [3:0] D;
    logic       VALID;
    logic       READY;
    logic       PERR;
    logic       FERR;
    logic       OVF;

    modport master (
        input  SIN,
        input  SEN,
        input  READY,
        output D,
        output VALID,
        output PERR,
        output FERR,
        output OVF
    );

    modport slave (
        output SIN,
        output SEN,
        output READY,
        input  D,
        input  VALID,
        input  PERR,
        input  FERR,
        input  OVF
    );
endinterface

// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - deserialises parity-protected 4-bit frames into a 1-entry output buffer
//
// Frame on SIN (one bit per SEN=1 cycle): start(0), d0..d3 (LSB first),
// parity, stop(1).  A good frame is written into a single-entry buffer
// (D/VALID) on the same edge that samples its stop bit.
//
// Parameters:
//   ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   CLK    clock, all state changes on the rising edge
//   CLR    synchronous active-high reset, overrides every other input
//   bus    serial_word_loader_if.master (SIN, SEN, READY in; D, VALID, PERR, FERR, OVF out)

module serial_word_loader #(
    parameter logic ODD = 1'b0
) (
    input  logic                        CLK,
    input  logic                        CLR,
    serial_word_loader_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t     state_q,   state_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] shreg_q,   shreg_d;
    logic       par_bad_q, par_bad_d;
    logic [3:0] d_q,       d_d;
    logic       valid_q,   valid_d;
    logic       perr_q,    perr_d;
    logic       ferr_q,    ferr_d;
    logic       ovf_q,     ovf_d;

    // Set on the stop-bit edge of a frame with correct parity and stop bit.
    logic       frame_done;
    // Downstream takes the buffered word on this edge.
    logic       xfer;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= IDLE;
            bit_cnt_q <= 2'd0;
            shreg_q   <= 4'h0;
            par_bad_q <= 1'b0;
            d_q       <= 4'h0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            d_q       <= d_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver: next state, shift register, error pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_bad_d  = par_bad_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        frame_done = 1'b0;

        // Nothing moves on SEN=0 cycles; SIN is don't-care there.
        if (bus.SEN) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.SIN) begin
                        state_d   = DATA;
                        bit_cnt_d = 2'd0;
                        shreg_d   = 4'h0;
                    end
                end

                DATA: begin
                    shreg_d[bit_cnt_q] = bus.SIN;
                    bit_cnt_d          = bit_cnt_q + 2'd1;
                    if (bit_cnt_q == 2'd3) begin
                        state_d = PAR;
                    end
                end

                PAR: begin
                    // Parity verdict is kept until the stop bit decides
                    // whether the frame is a framing or a parity failure.
                    par_bad_d = (((^shreg_q) ^ bus.SIN) != ODD);
                    state_d   = STOP;
                end

                STOP: begin
                    state_d   = IDLE;
                    bit_cnt_d = 2'd0;
                    // A bad stop bit masks any parity problem.
                    if (!bus.SIN) begin
                        ferr_d = 1'b1;
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
                    end else begin
                        frame_done = 1'b1;
                    end
                end

                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output buffer
    // ------------------------------------------------------------------
    always_comb begin
        xfer    = valid_q & bus.READY;
        d_d     = d_q;
        valid_d = valid_q & ~xfer;
        ovf_d   = ovf_q;

        if (frame_done) begin
            // The buffer has room if it is empty or is being emptied on
            // this very edge; otherwise the new word is lost and the old
            // one is kept untouched.
            if (!valid_q || bus.READY) begin
                d_d     = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovf_d   = 1'b1;
            end
        end
    end

    assign bus.D     = d_q;
    assign bus.VALID = valid_q;
    assign bus.PERR  = perr_q;
    assign bus.FERR  = ferr_q;
    assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - scoreboard bench for serial_word_loader

module tb_serial_word_loader;

    localparam logic ODD = 1'b0;

    typedef enum int {EV_NONE, EV_WORD, EV_PERR, EV_FERR} ev_t;

    logic CLK = 1'b0;
    logic CLR;

    serial_word_loader_if bus ();

    serial_word_loader #(.ODD(ODD)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       mon_en  = 1'b0;

    // Frame-level reference: contents of the one-word buffer and OVF.
    logic       m_valid = 1'b0;
    logic [3:0] m_d     = 4'h0;
    logic       m_ovf   = 1'b0;
    logic [3:0] exp_q[$];     // words expected to be handed downstream, in order
    logic       err_q[$];     // expected error pulses: 0 = PERR, 1 = FERR

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic pick_rdy(input int rmode, input logic last);
        case (rmode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(1));
            default: return last;
        endcase
    endfunction

    // Drive one clock of inputs; ev says what frame outcome this edge
    // produces (known to the stimulus because it built the frame).
    task automatic step(input logic sin, input logic sen, input logic rdy, input logic clr,
                        input ev_t ev, input logic [3:0] wd);
        logic       nv, no;
        logic [3:0] nd;
        bus.SIN   = sin;
        bus.SEN   = sen;
        bus.READY = rdy;
        CLR       = clr;
        if (clr) begin
            nv = 1'b0; nd = 4'h0; no = 1'b0;
            exp_q.delete();
        end else begin
            nv = m_valid && !rdy;
            nd = m_d;
            no = m_ovf;
            case (ev)
                EV_WORD: begin
                    if (!m_valid || rdy) begin
                        nv = 1'b1;
                        nd = wd;
                        exp_q.push_back(wd);
                    end else begin
                        no = 1'b1;
                    end
                end
                EV_PERR: err_q.push_back(1'b0);
                EV_FERR: err_q.push_back(1'b1);
                default: ;
            endcase
        end
        @(posedge CLK);
        #1;
        m_valid = nv;
        m_d     = nd;
        m_ovf   = no;
    endtask

    // gap < 0: exactly one SEN=0 cycle before every bit; otherwise gap is
    // the percentage chance of inserting each extra SEN=0 cycle.
    task automatic send_frame(input logic [3:0] data, input logic bad_par, input logic bad_stop,
                              input int gap, input int rmode);
        logic [6:0] bits;
        ev_t        ev;
        bits = {~bad_stop, (^data) ^ ODD ^ bad_par, data, 1'b0};
        ev   = bad_stop ? EV_FERR : (bad_par ? EV_PERR : EV_WORD);
        for (int i = 0; i < 7; i++) begin
            if (gap < 0) begin
                step(1'($urandom_range(1)), 1'b0, pick_rdy(rmode, 1'b0), 1'b0, EV_NONE, 4'h0);
            end else begin
                while ($urandom_range(99) < gap)
                    step(1'($urandom_range(1)), 1'b0, pick_rdy(rmode, 1'b0), 1'b0, EV_NONE, 4'h0);
            end
            step(bits[i], 1'b1, pick_rdy(rmode, i == 6), 1'b0, (i == 6) ? ev : EV_NONE, data);
        end
    endtask

    // Monitor: compares buffer state every cycle and pops the scoreboard
    // whenever the DUT hands a word over or pulses an error.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("valid", bus.VALID, m_valid);
            check("d", bus.D, m_d);
            check("ovf", bus.OVF, m_ovf);
            if (bus.VALID && bus.READY && !CLR) begin
                check("xfer_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("xfer_d", bus.D, exp_q.pop_front());
            end
            if (bus.PERR || bus.FERR) begin
                check("err_pending", err_q.size() > 0, 1);
                if (err_q.size() > 0)
                    check("err_kind", {bus.PERR, bus.FERR}, err_q.pop_front() ? 2'b01 : 2'b10);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.SIN = 1'b1; bus.SEN = 1'b0; bus.READY = 1'b0; CLR = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, EV_NONE, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, EV_NONE, 4'h0);
        check("rst_d", bus.D, 4'h0);
        check("rst_valid", bus.VALID, 1'b0);
        check("rst_ovf", bus.OVF, 1'b0);
        check("rst_perr", bus.PERR, 1'b0);
        check("rst_ferr", bus.FERR, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0);

        // Good frame 4'hB, READY low
        send_frame(4'hB, 1'b0, 1'b0, 0, 0);
        check("b_d", bus.D, 4'hB);
        check("b_valid", bus.VALID, 1'b1);
        check("b_perr", bus.PERR, 1'b0);
        check("b_ferr", bus.FERR, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0);

        // Same frame, wrong parity
        send_frame(4'hB, 1'b1, 1'b0, 0, 0);
        check("par_perr", bus.PERR, 1'b1);
        check("par_valid", bus.VALID, 1'b0);
        check("par_d", bus.D, 4'hB);
        step(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0);
        check("par_perr_clear", bus.PERR, 1'b0);

        // Frame 4'h5 with a bad stop bit, then a good frame proves return to IDLE
        send_frame(4'h5, 1'b0, 1'b1, 0, 0);
        check("stop_ferr", bus.FERR, 1'b1);
        check("stop_perr", bus.PERR, 1'b0);
        check("stop_valid", bus.VALID, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0);
        check("stop_ferr_clear", bus.FERR, 1'b0);
        send_frame(4'hB, 1'b0, 1'b0, 0, 0);
        check("after_ferr_d", bus.D, 4'hB);

        // Overflow while full, then back-to-back load with READY on the completion edge
        send_frame(4'h3, 1'b0, 1'b0, 0, 0);
        check("ovf_set", bus.OVF, 1'b1);
        check("ovf_keep_d", bus.D, 4'hB);
        send_frame(4'h3, 1'b0, 1'b0, 0, 3);
        check("b2b_d", bus.D, 4'h3);
        check("b2b_valid", bus.VALID, 1'b1);
        check("ovf_sticky", bus.OVF, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, EV_NONE, 4'h0);
        check("clr_ovf", bus.OVF, 1'b0);

        // SEN alternating during frame 4'hA
        send_frame(4'hA, 1'b0, 1'b0, -1, 0);
        check("sen_d", bus.D, 4'hA);
        step(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0);

        // CLR after two data bits, then a fresh frame 4'h6
        step(1'b0, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, EV_NONE, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, EV_NONE, 4'h0);
        send_frame(4'h6, 1'b0, 1'b0, 0, 0);
        check("abort_d", bus.D, 4'h6);
        check("abort_ovf", bus.OVF, 1'b0);
        check("abort_valid", bus.VALID, 1'b1);

        // Randomised traffic
        for (int f = 0; f < 200; f++) begin
            int idle;
            idle = $urandom_range(3);
            for (int k = 0; k < idle; k++)
                step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, EV_NONE, 4'h0);
            if ($urandom_range(99) < 4)
                step(1'b1, 1'b1, 1'b0, 1'b1, EV_NONE, 4'h0);
            send_frame(4'($urandom_range(15)), $urandom_range(99) < 15, $urandom_range(99) < 10,
                       30, 2);
        end

        step(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, EV_NONE, 4'h0);
        @(negedge CLK);
        #1;
        check("words_left", exp_q.size(), 0);
        check("errors_left", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 The block SHALL have one parameter, ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 CLR  input  1  SHALL be a synchronous, active-high reset.
REQ-004 SIN  input  1  SHALL carry serial frame data; the line idles high.
REQ-005 SEN  input  1  SHALL be the bit-sample enable; SIN is sampled only on cycles with SEN=1.
REQ-006 D  output  4  SHALL carry the assembled parallel word for the downstream 4-bit register.
REQ-007 VALID  output  1  SHALL indicate that D holds an unconsumed word.
REQ-008 READY  input  1  SHALL indicate that the downstream register accepts D this cycle.
REQ-009 PERR  output  1  SHALL be a one-cycle parity-error pulse.
REQ-010 FERR  output  1  SHALL be a one-cycle framing-error pulse.
REQ-011 OVF  output  1  SHALL be a sticky overflow flag.

Function
REQ-012 Frame format SHALL be: start bit (0), 4 data bits LSB first, 1 parity bit, stop bit (1); 7 sampled bits total.
REQ-013 The FSM SHALL have states IDLE, DATA, PAR, STOP; it advances only on SEN=1 cycles and holds otherwise.
REQ-014 IDLE: SEN=1 and SIN=0 SHALL go to DATA with bit count 0; SEN=1 and SIN=1 SHALL stay in IDLE.
REQ-015 DATA: each sampled bit SHALL shift into a 4-bit shift register at position bit count; after the 4th bit SHALL go to PAR.
REQ-016 PAR: the parity bit SHALL be sampled; error when XOR(data bits, parity bit) differs from ODD; SHALL go to STOP.
REQ-017 STOP: SIN=1 and parity good SHALL complete the frame; the FSM SHALL return to IDLE in all cases.
REQ-018 If the stop bit is 0, FERR SHALL pulse for one cycle and the frame SHALL be dropped; FERR takes priority over PERR.
REQ-019 If the stop bit is 1 and parity is bad, PERR SHALL pulse for one cycle and the frame SHALL be dropped.
REQ-020 A completed frame SHALL load a 1-entry output buffer; D and VALID SHALL update on the edge that samples the stop bit (latency 0 cycles after the stop-bit sample edge).
REQ-021 Handshake: a transfer occurs on any edge with VALID=1 and READY=1; VALID SHALL then clear unless a new frame completes on the same edge.
REQ-022 While VALID=1 and no transfer occurs, D SHALL remain stable.
REQ-023 Frame completion on an edge with VALID=1 and READY=1 SHALL load the new word; VALID SHALL remain 1 (back-to-back).
REQ-024 Frame completion on an edge with VALID=1 and READY=0 SHALL drop the new word, keep D unchanged, and set OVF.
REQ-025 Shifting of a new frame SHALL proceed while the output buffer is full.
REQ-026 OVF SHALL remain 1 until CLR.
REQ-027 READY while VALID=0 SHALL have no effect.

Reset
REQ-028 CLR=1 at a clock edge SHALL force the following: state IDLE, bit count 0, shift register 0, D=4'h0, VALID=0, PERR=0, FERR=0, OVF=0.
REQ-029 CLR SHALL override all other inputs, including SEN and READY.
REQ-030 CLR asserted mid-frame SHALL discard the partial frame; the next start bit begins a fresh frame.

Verification
REQ-031 Even parity (ODD=0), READY=0, SEN=1 every cycle, SIN=0,1,1,0,1,1,1 SHALL give D=4'hB and VALID=1 on the 7th edge, with PERR=FERR=0.
REQ-032 Same frame with parity bit 0 SHALL produce a one-cycle PERR pulse, keep VALID=0, and leave D unchanged.
REQ-033 Frame 4'h5 with stop bit 0 SHALL produce a one-cycle FERR pulse, keep VALID=0, and return the FSM to IDLE.
REQ-034 With VALID=1 (D=4'hB), READY=0, and frame 4'h3 completing SHALL set OVF=1 and keep D=4'hB; a second run with READY=1 on the completion edge SHALL give D=4'h3 with VALID=1.
REQ-035 SEN toggling 1,0,1,0 during frame 4'hA SHALL ignore SEN=0 cycles and still deliver D=4'hA.
REQ-036 CLR pulsed after 2 data bits, then a full frame 4'h6, SHALL deliver D=4'h6 with OVF=0.
